// File: rtl/hack_cpu.sv
// Hack CPU core: A/D/PC register file, decoder and jump unit around hack_alu.
// One instruction commits per accepted fetch; results are visible the next cycle.

// hack_alu: the Hack ALU function selected by {zx,nx,zy,ny,f,no}.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module hack_alu (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_zx,
  input  logic        i_nx,
  input  logic        i_zy,
  input  logic        i_ny,
  input  logic        i_f,
  input  logic        i_no,
  output logic [15:0] o_out,
  output logic        o_zr,
  output logic        o_ng
);

  logic [15:0] w_x0;
  logic [15:0] w_x1;
  logic [15:0] w_y0;
  logic [15:0] w_y1;
  logic [15:0] w_fn;

  assign w_x0  = i_zx ? 16'h0000 : i_x;
  assign w_x1  = i_nx ? ~w_x0 : w_x0;
  assign w_y0  = i_zy ? 16'h0000 : i_y;
  assign w_y1  = i_ny ? ~w_y0 : w_y0;
  assign w_fn  = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
  assign o_out = i_no ? ~w_fn : w_fn;
  assign o_zr  = (o_out == 16'h0000);
  assign o_ng  = o_out[15];

endmodule

// hack_cpu: fetch consumer, decoder, A/D/PC registers and jump unit.
// Latency: one cycle per committed instruction.
// Backpressure: stalls on instr_valid=0 or on a write with mem_ready=0; halts on illegal encodings.
module hack_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic [15:0] in_m,
  input  logic        mem_ready,
  output logic [15:0] out_m,
  output logic        write_m,
  output logic [14:0] address_m,
  output logic [14:0] pc,
  output logic        halted,
  output logic [31:0] retired
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;

  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [14:0] r_pc;
  logic [31:0] r_retired;
  logic        r_state;

  logic        w_is_c;
  logic        w_legal;
  logic        w_active;
  logic        w_sel_m;
  logic [2:0]  w_dest;
  logic [2:0]  w_jmp;
  logic [15:0] w_alu_y;
  logic [15:0] w_alu_out;
  logic        w_zr;
  logic        w_ng;
  logic        w_jump;
  logic        w_write;
  logic        w_commit;
  logic [14:0] w_pc_inc;

  assign w_is_c   = instr[15];
  assign w_legal  = ~instr[15] | (instr[14:13] == 2'b11);
  assign w_sel_m  = instr[12];
  assign w_dest   = instr[5:3];
  assign w_jmp    = instr[2:0];

  // Anything that can change state or drive memory is gated on this.
  assign w_active = ~reset & (r_state == ST_RUN) & instr_valid;

  assign w_alu_y  = w_sel_m ? in_m : r_a;

  hack_alu u_alu (
    .i_x   (r_d),
    .i_y   (w_alu_y),
    .i_zx  (instr[11]),
    .i_nx  (instr[10]),
    .i_zy  (instr[9]),
    .i_ny  (instr[8]),
    .i_f   (instr[7]),
    .i_no  (instr[6]),
    .o_out (w_alu_out),
    .o_zr  (w_zr),
    .o_ng  (w_ng)
  );

  assign w_jump   = w_is_c & ((w_jmp[2] & w_ng) |
                              (w_jmp[1] & w_zr) |
                              (w_jmp[0] & ~w_zr & ~w_ng));
  assign w_write  = w_active & w_is_c & w_legal & w_dest[0];
  assign w_commit = w_active & w_legal & (~w_write | mem_ready);
  assign w_pc_inc = r_pc + 15'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= 16'h0000;
      r_d       <= 16'h0000;
      r_pc      <= 15'h0000;
      r_retired <= 32'h0000_0000;
      r_state   <= ST_RUN;
    end else if (w_active & ~w_legal) begin
      r_state <= ST_HALT;
    end else if (w_commit) begin
      r_retired <= r_retired + 32'd1;
      if (w_is_c) begin
        if (w_dest[2]) r_a <= w_alu_out;
        if (w_dest[1]) r_d <= w_alu_out;
        // r_a on the right-hand side is the pre-commit A even when dA=1.
        r_pc <= w_jump ? r_a[14:0] : w_pc_inc;
      end else begin
        r_a  <= {1'b0, instr[14:0]};
        r_pc <= w_pc_inc;
      end
    end
  end

  assign out_m     = w_alu_out;
  assign write_m   = w_write;
  assign address_m = r_a[14:0];
  assign pc        = r_pc;
  assign halted    = (r_state == ST_HALT);
  assign retired   = r_retired;

endmodule

// File: tb/tb_hack_cpu.sv
// Directed bench for hack_cpu: each cycle's expected outputs are queued by the
// driver and compared by a negedge monitor.
module tb_hack_cpu;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] in_m;
  logic        mem_ready;
  logic [15:0] out_m;
  logic        write_m;
  logic [14:0] address_m;
  logic [14:0] pc;
  logic        halted;
  logic [31:0] retired;

  hack_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .in_m        (in_m),
    .mem_ready   (mem_ready),
    .out_m       (out_m),
    .write_m     (write_m),
    .address_m   (address_m),
    .pc          (pc),
    .halted      (halted),
    .retired     (retired)
  );

  typedef struct {
    int          id;
    logic [14:0] pc;
    logic [14:0] addr;
    logic        wr;
    logic        chk_out;
    logic [15:0] outv;
    logic        halt;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;
  int   step_id;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input int id, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", id, fld, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, after the driver updated inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.id, "pc", {17'd0, pc}, {17'd0, e.pc});
        chk(e.id, "address_m", {17'd0, address_m}, {17'd0, e.addr});
        chk(e.id, "write_m", {31'd0, write_m}, {31'd0, e.wr});
        chk(e.id, "halted", {31'd0, halted}, {31'd0, e.halt});
        chk(e.id, "retired", retired, e.ret);
        if (e.chk_out) chk(e.id, "out_m", {16'd0, out_m}, {16'd0, e.outv});
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic rst, input logic [15:0] ins, input logic vld,
                      input logic [15:0] mdat, input logic rdy,
                      input logic [14:0] e_pc, input logic [14:0] e_addr,
                      input logic e_wr, input logic e_chk, input logic [15:0] e_out,
                      input logic e_halt, input logic [31:0] e_ret);
    exp_t e;
    reset       = rst;
    instr       = ins;
    instr_valid = vld;
    in_m        = mdat;
    mem_ready   = rdy;
    step_id++;
    e.id = step_id; e.pc = e_pc; e.addr = e_addr; e.wr = e_wr;
    e.chk_out = e_chk; e.outv = e_out; e.halt = e_halt; e.ret = e_ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; step_id = 0;
    reset = 1'b1; instr = 16'h0000; instr_valid = 1'b0; in_m = 16'h0000; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //    rst  instr    v  in_m     rdy  pc       addr     wr chk out      hlt ret
    step(0, 16'h0005, 1, 16'h0000, 0, 15'd0,   15'd0,   0, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 16'h0005, 0, 16'h0000, 0, 15'd1, 15'd5,   0, 0, 16'h0000, 0, 1);
    step(0, 16'hEC10, 1, 16'h0000, 0, 15'd1,   15'd5,   0, 1, 16'h0005, 0, 1);
    step(0, 16'h0007, 1, 16'h0000, 0, 15'd2,   15'd5,   0, 0, 16'h0000, 0, 2);
    step(0, 16'hE090, 1, 16'h0000, 0, 15'd3,   15'd7,   0, 1, 16'h000C, 0, 3);
    step(0, 16'h0064, 1, 16'h0000, 0, 15'd4,   15'd7,   0, 0, 16'h0000, 0, 4);
    // M=D held against mem_ready=0 for two cycles.
    step(0, 16'hE308, 1, 16'h0000, 0, 15'd5,   15'd100, 1, 1, 16'h000C, 0, 5);
    step(0, 16'hE308, 1, 16'h0000, 0, 15'd5,   15'd100, 1, 1, 16'h000C, 0, 5);
    step(0, 16'hE308, 1, 16'h0000, 1, 15'd5,   15'd100, 1, 1, 16'h000C, 0, 5);
    step(0, 16'h0014, 1, 16'h0000, 0, 15'd6,   15'd100, 0, 0, 16'h0000, 0, 6);
    step(0, 16'hEA90, 1, 16'h0000, 0, 15'd7,   15'd20,  0, 1, 16'h0000, 0, 7);
    step(0, 16'hE302, 1, 16'h0000, 0, 15'd8,   15'd20,  0, 1, 16'h0000, 0, 8);
    step(0, 16'hEFD0, 1, 16'h0000, 0, 15'd20,  15'd20,  0, 1, 16'h0001, 0, 9);
    step(0, 16'hE302, 1, 16'h0000, 0, 15'd21,  15'd20,  0, 1, 16'h0001, 0, 10);
    step(0, 16'h7FFF, 1, 16'h0000, 0, 15'd22,  15'd20,  0, 0, 16'h0000, 0, 11);
    step(0, 16'hEA87, 1, 16'h0000, 0, 15'd23,  15'h7FFF,0, 1, 16'h0000, 0, 12);
    step(0, 16'h0001, 1, 16'h0000, 0, 15'h7FFF,15'h7FFF,0, 0, 16'h0000, 0, 13);
    // A=D+1;JMP: target is the old A (1), A becomes 2.
    step(0, 16'hE7E7, 1, 16'h0000, 0, 15'd0,   15'd1,   0, 1, 16'h0002, 0, 14);
    // AM=M+1: write goes to old A (2), A takes the result.
    step(0, 16'hFDE8, 1, 16'h1234, 1, 15'd1,   15'd2,   1, 1, 16'h1235, 0, 15);
    step(0, 16'hFDE8, 0, 16'h1234, 1, 15'd2,   15'h1235,0, 0, 16'h0000, 0, 16);
    step(0, 16'h8000, 1, 16'h0000, 1, 15'd2,   15'h1235,0, 0, 16'h0000, 0, 16);
    for (int i = 0; i < 5; i++)
      step(0, 16'hE308, 1, 16'h0000, 1, 15'd2, 15'h1235,0, 0, 16'h0000, 1, 16);
    step(1, 16'hE308, 1, 16'h0000, 1, 15'd2,   15'h1235,0, 0, 16'h0000, 1, 16);
    step(0, 16'h0064, 1, 16'h0000, 1, 15'd0,   15'd0,   0, 0, 16'h0000, 0, 0);
    step(0, 16'hE308, 1, 16'h0000, 0, 15'd1,   15'd100, 1, 1, 16'h0000, 0, 1);
    step(1, 16'hE308, 1, 16'h0000, 0, 15'd1,   15'd100, 0, 0, 16'h0000, 0, 1);
    step(0, 16'hE308, 0, 16'h0000, 0, 15'd0,   15'd0,   0, 0, 16'h0000, 0, 0);
    instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
